// File: rtl/ls138_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : ls138_rr_arbiter_if
//  Description : Request/enable inputs and LS138 decoder-drive outputs of
//                the eight-way round-robin decoder arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
interface ls138_rr_arbiter_if;
    logic       en;     // global arbitration enable
    logic [7:0] req;    // per-requester request, active-high
    logic       a2;     // decoder select, MSB
    logic       a1;
    logic       a0;     // decoder select, LSB
    logic       g1;     // decoder enable, active-high
    logic       g2a;    // decoder enable, active-low
    logic       g2b;    // decoder enable, active-low
    logic       busy;   // grant in progress
    logic       tmo;    // hold-time expiry pulse

    // Requester side: drives requests, observes the decoder drive
    modport master (
        output en, req,
        input  a2, a1, a0, g1, g2a, g2b, busy, tmo
    );

    // Arbiter side
    modport slave (
        input  en, req,
        output a2, a1, a0, g1, g2a, g2b, busy, tmo
    );
endinterface
`default_nettype wire

// File: rtl/ls138_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ls138_rr_arbiter
//  Description : Eight-way round-robin arbiter owning one LS138 3-to-8
//                decoder. Bounded hold time, one disabled guard cycle
//                between owners, all outputs registered.
//  Revision    : 1.0  initial release
// ============================================================================
module ls138_rr_arbiter #(
    parameter int HOLD_MAX = 15     // legal range 1..255
) (
    input  wire logic           clk,
    input  wire logic           rst,
    ls138_rr_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_GUARD = 2'd2
    } state_t;

    // CNT value seen during the last permitted grant cycle
    localparam logic [7:0] c_cnt_last = 8'(HOLD_MAX - 1);

    state_t     r_state, w_state_nxt;
    logic [2:0] r_own,   w_own_nxt;
    logic [2:0] r_last,  w_last_nxt;
    logic [7:0] r_cnt,   w_cnt_nxt;
    logic       r_g1,    w_g1_nxt;
    logic       r_busy,  w_busy_nxt;
    logic       r_tmo,   w_tmo_nxt;

    logic [2:0] w_win;
    logic [2:0] w_idx;
    logic       w_any;

    // Round-robin winner: scan from LAST+8 (== LAST) down to LAST+1 so the
    // closest requester after LAST is written last and therefore wins.
    always_comb begin
        w_win = r_last;
        w_idx = '0;
        w_any = |bus.req;
        for (int k = 8; k >= 1; k--) begin
            w_idx = r_last + 3'(k);
            if (bus.req[w_idx]) begin
                w_win = w_idx;
            end
        end
    end

    // Next-state and next-output decode
    always_comb begin
        w_state_nxt = r_state;
        w_own_nxt   = r_own;
        w_last_nxt  = r_last;
        w_cnt_nxt   = r_cnt;
        w_tmo_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.en && w_any) begin
                    w_state_nxt = S_GRANT;
                    w_own_nxt   = w_win;
                    w_cnt_nxt   = 8'd0;
                end
            end
            S_GRANT: begin
                // EN deliberately ignored: an active grant runs to completion
                w_cnt_nxt = r_cnt + 8'd1;
                if (!bus.req[r_own]) begin
                    // release takes precedence over a coincident timeout
                    w_state_nxt = S_GUARD;
                    w_last_nxt  = r_own;
                end else if (r_cnt == c_cnt_last) begin
                    w_state_nxt = S_GUARD;
                    w_last_nxt  = r_own;
                    w_tmo_nxt   = 1'b1;
                end
            end
            S_GUARD: begin
                // LAST already equals the previous owner here
                if (bus.en && w_any) begin
                    w_state_nxt = S_GRANT;
                    w_own_nxt   = w_win;
                    w_cnt_nxt   = 8'd0;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        w_g1_nxt   = (w_state_nxt == S_GRANT);
        w_busy_nxt = (w_state_nxt == S_GRANT);
    end

    // State and output registers; reset drops the enables on the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_own   <= 3'd0;
            r_last  <= 3'd7;
            r_cnt   <= 8'd0;
            r_g1    <= 1'b0;
            r_busy  <= 1'b0;
            r_tmo   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_own   <= w_own_nxt;
            r_last  <= w_last_nxt;
            r_cnt   <= w_cnt_nxt;
            r_g1    <= w_g1_nxt;
            r_busy  <= w_busy_nxt;
            r_tmo   <= w_tmo_nxt;
        end
    end

    assign bus.a2   = r_own[2];
    assign bus.a1   = r_own[1];
    assign bus.a0   = r_own[0];
    assign bus.g1   = r_g1;
    assign bus.g2a  = ~r_g1;
    assign bus.g2b  = ~r_g1;
    assign bus.busy = r_busy;
    assign bus.tmo  = r_tmo;

endmodule
`default_nettype wire

// File: tb/tb_ls138_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ls138_rr_arbiter
//  Description : Directed scenarios plus random request traffic for
//                ls138_rr_arbiter, compared cycle by cycle against a
//                behavioural model of the arbitration rules.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ls138_rr_arbiter;

    localparam int HOLD = 4;

    logic clk;
    logic rst;
    ls138_rr_arbiter_if bus ();

    ls138_rr_arbiter #(.HOLD_MAX(HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    n_vec;
    int    n_err;
    string phase;

    // Model: mode 0 idle, 1 granted, 2 guard; held = grant cycles so far
    int m_mode;
    int m_own;
    int m_last;
    int m_held;
    bit m_tmo;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %b expected %b (a2a1a0 g1 g2a g2b busy tmo)",
                     tag, $time, got, exp);
        end
    endtask

    // First requester after 'last' in circular order; 'last' itself comes last
    function automatic int pick(input logic [7:0] q, input int last);
        for (int k = 1; k <= 8; k++) begin
            int i;
            i = (last + k) % 8;
            if (q[i]) return i;
        end
        return last;
    endfunction

    task automatic model_edge(input logic r, input logic e, input logic [7:0] q);
        if (r) begin
            m_mode = 0; m_own = 0; m_last = 7; m_held = 0; m_tmo = 1'b0;
        end else begin
            m_tmo = 1'b0;
            case (m_mode)
                0: begin
                    if (e && q != 8'h00) begin
                        m_own = pick(q, m_last); m_held = 1; m_mode = 1;
                    end
                end
                1: begin
                    if (!q[m_own]) begin
                        m_mode = 2; m_last = m_own;
                    end else if (m_held == HOLD) begin
                        m_mode = 2; m_last = m_own; m_tmo = 1'b1;
                    end else begin
                        m_held++;
                    end
                end
                default: begin
                    if (e && q != 8'h00) begin
                        m_own = pick(q, m_last); m_held = 1; m_mode = 1;
                    end else begin
                        m_mode = 0;
                    end
                end
            endcase
        end
    endtask

    task automatic step(input logic r, input logic e, input logic [7:0] q);
        bit         g;
        logic [2:0] a;
        rst     = r;
        bus.en  = e;
        bus.req = q;
        @(posedge clk);
        model_edge(r, e, q);
        #1;
        g = (m_mode == 1);
        a = 3'(m_own);
        chk(phase,
            {bus.a2, bus.a1, bus.a0, bus.g1, bus.g2a, bus.g2b, bus.busy, bus.tmo},
            {a, g, ~g, ~g, g, m_tmo});
    endtask

    initial begin
        logic [7:0] q;
        logic       e;
        logic       r;
        n_vec   = 0;
        n_err   = 0;
        rst     = 1'b1;
        bus.en  = 1'b1;
        bus.req = 8'hFF;

        phase = "reset";
        repeat (2) step(1'b1, 1'b1, 8'hFF);

        phase = "single";
        step(1'b0, 1'b1, 8'h00);
        repeat (3) step(1'b0, 1'b1, 8'h04);
        repeat (3) step(1'b0, 1'b1, 8'h00);

        phase = "saturate";
        step(1'b1, 1'b1, 8'h00);
        repeat (45) step(1'b0, 1'b1, 8'hFF);
        repeat (3) step(1'b0, 1'b1, 8'h00);

        phase = "wrap";
        step(1'b1, 1'b1, 8'h00);
        repeat (2) step(1'b0, 1'b1, 8'h20);
        step(1'b0, 1'b1, 8'h00);
        repeat (12) step(1'b0, 1'b1, 8'h21);
        repeat (2) step(1'b0, 1'b1, 8'h00);

        phase = "rst_mid";
        step(1'b1, 1'b1, 8'h00);
        repeat (2) step(1'b0, 1'b1, 8'h08);
        step(1'b1, 1'b1, 8'h09);
        repeat (12) step(1'b0, 1'b1, 8'h09);
        repeat (2) step(1'b0, 1'b1, 8'h00);

        phase = "en_gate";
        repeat (5) step(1'b0, 1'b0, 8'h80);
        repeat (3) step(1'b0, 1'b1, 8'h80);
        repeat (2) step(1'b0, 1'b1, 8'h00);

        phase = "random";
        q = 8'h00;
        for (int n = 0; n < 3000; n++) begin
            for (int b = 0; b < 8; b++) begin
                if ($urandom_range(7) == 0) q[b] = ~q[b];
            end
            e = ($urandom_range(9) != 0);
            r = ($urandom_range(149) == 0);
            step(r, e, q);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ls138_rr_arbiter.md
# ls138_rr_arbiter

Eight-way round-robin arbiter that shares one LS138 3-to-8 decoder between eight requesters. It decides which requester owns the decoder, drives the decoder's select lines (A2..A0) and enables (G1, G2A, G2B), and enforces a maximum hold time plus a one-cycle guard gap between owners. It sits directly in front of the LS138 instance; the decoder's active-low Y0..Y7 become the per-requester select strobes.

## Interface

Parameters:
- HOLD_MAX, 15: maximum consecutive cycles one owner keeps the decoder enabled; legal range 1..255.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RST  input  1  reset: synchronous, active-high; one clock; overrides every other input.
- EN  input  1  global arbitration enable; when 0, no new grant is issued.
- REQ  input  8  request vector, active-high; REQ[i] is held high for as long as requester i wants the decoder.
- A2, A1, A0  output  1 each  decoder select = index of the current owner.
- G1  output  1  decoder enable, active-high; 1 only while a grant is active.
- G2A, G2B  output  1 each  decoder enables, active-low; both equal ~G1.
- BUSY  output  1  high while in GRANT.
- TMO  output  1  one-cycle pulse in the GUARD cycle entered by hold-time expiry.

## Operation

- All outputs are registered. There is no combinational path from REQ or EN to any output.
- The state machine has three states: IDLE, GRANT and GUARD. It also keeps an owner register OWN[2:0], a priority pointer LAST[2:0] and a hold counter CNT[7:0].
- Winner selection: the first requester i with REQ[i]=1, searching LAST+1, LAST+2, ... modulo 8 (wraps from 7 to 0). LAST itself is searched last.
- IDLE:
  - If EN=1 and any REQ bit is set: load OWN = winner, clear CNT, go to GRANT.
  - Otherwise stay in IDLE.
- GRANT:
  - A2..A0 = OWN, G1=1, G2A=G2B=0, BUSY=1.
  - CNT increments each cycle.
  - If REQ[OWN]=0, go to GUARD (release).
  - Else if CNT = HOLD_MAX-1, go to GUARD with TMO=1 (timeout).
  - Otherwise stay in GRANT.
  - EN is ignored while in GRANT; the current grant runs to completion.
- GUARD:
  - G1=0, G2A=G2B=1, BUSY=0. A2..A0 hold the last OWN value.
  - LAST loads OWN on entry to GUARD.
  - On exit, if EN=1 and any REQ bit is set, go straight to GRANT with the new winner. Otherwise go to IDLE.
  - A timed-out owner that is still the only requester wins again after the guard cycle.
- Reset values: state IDLE, A2..A0=000, G1=0, G2A=1, G2B=1, BUSY=0, TMO=0, LAST=7 (requester 0 has top priority after reset), CNT=0.
- RST asserted mid-grant: the enables drop at that same edge and all registers take their reset values. No GUARD cycle and no TMO pulse occur.
- Simultaneous events:
  - REQ[OWN] falling in the same cycle that CNT reaches HOLD_MAX-1 counts as a release, so TMO=0.
  - A requester whose REQ is already high before it is granted is served only on its round-robin turn.
- The decoder is never enabled for two owners without at least one disabled cycle between them. A2..A0 never change while G1=1.

## Timing

- Grant latency:
  - REQ sampled high in IDLE at edge n gives G1=1 with the correct A2..A0 after edge n.
  - A request arriving while another owner is active waits for that owner's release or timeout plus one GUARD cycle.
- Release: REQ[OWN] sampled low at edge m gives G1=0 after edge m.
- Grant length:
  - Minimum 1 cycle.
  - Maximum HOLD_MAX cycles. With HOLD_MAX=1, every grant lasts exactly 1 cycle and ends with TMO=1.
- Guard gap: exactly one cycle, whether the next grant is immediate or not.
- Saturated load (all REQ held): each owner gets HOLD_MAX cycles followed by 1 guard cycle, so the period is HOLD_MAX+1 cycles per owner.

## Test plan

Use HOLD_MAX=4 for all scenarios.

- Reset: RST=1 for 2 cycles with REQ=8'hFF -> G1=0, G2A=G2B=1, A2..A0=000, BUSY=0, TMO=0 throughout.
- Single request:
  - Stimulus: REQ=8'h04 for 3 cycles, then 8'h00.
  - Response: G1=1 with A2..A0=010 for exactly 3 cycles, starting 1 cycle after REQ rises; then one GUARD cycle with TMO=0; then IDLE.
- Saturation:
  - Stimulus: REQ=8'hFF held for 45 cycles.
  - Response: owners 0,1,...,7,0 in order, each with G1=1 for 4 cycles, TMO pulse then 1 gap cycle, 5-cycle period.
- Wrap-around: after owner 5 releases, REQ=8'b0010_0001 -> owner 0 wins (search order 6,7,0), then 5.
- Reset mid-grant:
  - Stimulus: during the owner-3 grant, RST=1 for 1 cycle while REQ=8'h09 is held.
  - Response: G1=0 at the RST edge with no TMO; after RST drops the next grant goes to 0, then 3.
- EN gating:
  - Stimulus: EN=0 with REQ=8'h80 for 5 cycles; then EN=1.
  - Response: no grant while EN=0; G1=1 with A2..A0=111 one cycle after EN is sampled high.
